// File: rtl/data_memory_mmio_if.sv
// CPU-side bus for data_memory_mmio.
//   addr     : word address (ADDR_W bits)
//   wr_en    : write strobe, sampled on the rising clock edge
//   rd_en    : read strobe, sampled on the rising clock edge
//   wr_data  : write data (DATA_W bits)
//   rd_data  : registered read data
//   rd_valid : high for one cycle after each rd_en cycle
// master = CPU side, slave = memory side.
interface data_memory_mmio_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] addr;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   modport master (
      output addr, wr_en, rd_en, wr_data,
      input  rd_data, rd_valid
   );

   modport slave (
      input  addr, wr_en, rd_en, wr_data,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/data_memory_mmio.sv
// Word-addressed data RAM with three memory-mapped port registers at the
// top of the address space:
//   all-ones     IN   : one-deep input holding register (read pops it)
//   all-ones - 1 OUT  : output data register with valid/ready handshake
//   all-ones - 2 STAT : {.., ovf, out_port_valid, input full}; write bit0=1 clears ovf
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus             : CPU bus (slave side), registered reads, rd_valid one cycle later
//   in_port_*       : external input, valid/ready; ready=1 while holding register empty
//   out_port_*      : external output, valid/ready
//   ovf             : sticky flag, set when an OUT write is dropped
// RAM contents are not reset.
module data_memory_mmio #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   data_memory_mmio_if.slave bus,
   input  logic [DATA_W-1:0] in_port_data,
   input  logic              in_port_valid,
   output logic              in_port_ready,
   output logic [DATA_W-1:0] out_port_data,
   output logic              out_port_valid,
   input  logic              out_port_ready,
   output logic              ovf
);

   localparam logic [ADDR_W-1:0] IN_ADDR   = '1;
   localparam logic [ADDR_W-1:0] OUT_ADDR  = IN_ADDR - ADDR_W'(1);
   localparam logic [ADDR_W-1:0] STAT_ADDR = IN_ADDR - ADDR_W'(2);

   typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;

   in_state_t         in_state, in_state_nxt;
   logic [DATA_W-1:0] in_hold;
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_mux;

   logic is_in, is_out, is_stat, is_ram;
   logic in_take, out_wr, out_accept, out_drop;

   always_comb begin
      is_in      = (bus.addr == IN_ADDR);
      is_out     = (bus.addr == OUT_ADDR);
      is_stat    = (bus.addr == STAT_ADDR);
      is_ram     = !(is_in || is_out || is_stat);
      in_take    = bus.rd_en && is_in && (in_state == IN_FULL);
      out_wr     = bus.wr_en && is_out;
      out_accept = out_wr && (!out_port_valid || out_port_ready);
      out_drop   = out_wr && out_port_valid && !out_port_ready;
   end

   // Input holding register FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_state <= IN_EMPTY;
      else        in_state <= in_state_nxt;
   end

   always_comb begin
      in_state_nxt = in_state;
      case (in_state)
         IN_EMPTY: if (in_port_valid) in_state_nxt = IN_FULL;
         IN_FULL:  if (in_take)       in_state_nxt = IN_EMPTY;
         default:                     in_state_nxt = IN_EMPTY;
      endcase
   end

   always_comb begin
      in_port_ready = (in_state == IN_EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            in_hold <= '0;
      else if (in_port_ready && in_port_valid) in_hold <= in_port_data;
   end

   // RAM: no reset, port-register addresses never touch it
   always_ff @(posedge clk) begin
      if (bus.wr_en && is_ram) mem[bus.addr] <= bus.wr_data;
   end

   // Read source uses pre-edge state, giving read-before-write everywhere
   always_comb begin
      rd_mux = '0;
      if (is_in) begin
         if (in_state == IN_FULL) rd_mux = in_hold;
      end else if (is_out) begin
         rd_mux = out_port_data;
      end else if (is_stat) begin
         rd_mux[2:0] = {ovf, out_port_valid, ~in_port_ready};
      end else begin
         rd_mux = mem[bus.addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) bus.rd_data <= rd_mux;
      end
   end

   // Output register and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_port_data  <= '0;
         out_port_valid <= 1'b0;
         ovf            <= 1'b0;
      end else begin
         if (out_accept) begin
            out_port_data  <= bus.wr_data;
            out_port_valid <= 1'b1;
         end else if (out_port_valid && out_port_ready) begin
            out_port_valid <= 1'b0;
         end
         // A drop in the same cycle wins over a clear
         if (out_drop)
            ovf <= 1'b1;
         else if (bus.wr_en && is_stat && bus.wr_data[0])
            ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: directed vector table, hand-written reset
// sequence, then randomized traffic against a behavioural model.
module tb_data_memory_mmio;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int OW = 1 + DW + 1 + 1 + DW + 1;
   localparam int A_IN   = (1 << AW) - 1;
   localparam int A_OUT  = (1 << AW) - 2;
   localparam int A_STAT = (1 << AW) - 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_memory_mmio_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   logic [DW-1:0] in_port_data;
   logic          in_port_valid;
   logic          in_port_ready;
   logic [DW-1:0] out_port_data;
   logic          out_port_valid;
   logic          out_port_ready;
   logic          ovf;

   data_memory_mmio #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus.slave),
      .in_port_data   (in_port_data),
      .in_port_valid  (in_port_valid),
      .in_port_ready  (in_port_ready),
      .out_port_data  (out_port_data),
      .out_port_valid (out_port_valid),
      .out_port_ready (out_port_ready),
      .ovf            (ovf)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic          we;
      logic          re;
      logic [DW-1:0] wd;
      logic          iv;
      logic [DW-1:0] id;
      logic          ordy;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t tbl [17];

   function automatic logic [OW-1:0] pack(input int rv, input int rd, input int ir,
                                          input int ov, input int od, input int of);
      return {1'(rv), DW'(rd), 1'(ir), 1'(ov), DW'(od), 1'(of)};
   endfunction

   function automatic vec_t v(input int a, input int we, input int re, input int wd,
                              input int iv, input int id, input int ordy,
                              input int rv, input int rd, input int ir,
                              input int ov, input int od, input int of);
      vec_t r;
      r.a = AW'(a); r.we = 1'(we); r.re = 1'(re); r.wd = DW'(wd);
      r.iv = 1'(iv); r.id = DW'(id); r.ordy = 1'(ordy);
      r.exp = pack(rv, rd, ir, ov, od, of);
      return r;
   endfunction

   function automatic logic [OW-1:0] observed();
      return {bus.rd_valid, bus.rd_data, in_port_ready, out_port_valid, out_port_data, ovf};
   endfunction

   task automatic check(input string name, input logic [OW-1:0] exp);
      logic [OW-1:0] act;
      act = observed();
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {rv,rd,ir,ov,od,ovf}=%h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [AW-1:0] a, input logic we, input logic re,
                        input logic [DW-1:0] wd, input logic iv, input logic [DW-1:0] id,
                        input logic ordy);
      bus.addr = a; bus.wr_en = we; bus.rd_en = re; bus.wr_data = wd;
      in_port_valid = iv; in_port_data = id; out_port_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: RAM as an associative array, input register as a
   // queue of at most one entry, output register as value + pending flag.
   logic [DW-1:0] m_mem [int];
   logic [DW-1:0] m_inq [$];
   logic [DW-1:0] m_out_data;
   logic          m_out_valid;
   logic          m_ovf;
   logic [DW-1:0] m_rd_data;
   logic          m_rd_valid;

   task automatic model_step(input int a, input logic we, input logic re,
                             input logic [DW-1:0] wd, input logic iv,
                             input logic [DW-1:0] id, input logic ordy);
      logic [DW-1:0] rv;
      if (a == A_IN)        rv = (m_inq.size() != 0) ? m_inq[0] : '0;
      else if (a == A_OUT)  rv = m_out_data;
      else if (a == A_STAT) rv = DW'({m_ovf, m_out_valid, m_inq.size() != 0});
      else                  rv = m_mem.exists(a) ? m_mem[a] : 'x;
      m_rd_valid = re;
      if (re) m_rd_data = rv;
      if (we && a < A_STAT) m_mem[a] = wd;
      if (re && a == A_IN && m_inq.size() != 0) void'(m_inq.pop_front());
      else if (m_inq.size() == 0 && iv)         m_inq.push_back(id);
      if (we && a == A_OUT) begin
         if (!m_out_valid || ordy) begin
            m_out_data  = wd;
            m_out_valid = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_out_valid && ordy) begin
         m_out_valid = 1'b0;
      end
      if (we && a == A_STAT && wd[0]) m_ovf = 1'b0;
   endtask

   task automatic rand_cycle(input int a, input logic we, input logic re, input logic [DW-1:0] wd,
                             input logic iv, input logic [DW-1:0] id, input logic ordy,
                             input string name);
      drive(AW'(a), we, re, wd, iv, id, ordy);
      model_step(a, we, re, wd, iv, id, ordy);
      tick();
      check(name, {m_rd_valid, m_rd_data, m_inq.size() == 0, m_out_valid, m_out_data, m_ovf});
   endtask

   initial begin
      tbl[0]  = v(16,     1,0,'hA5, 0,0,   0,  0,'h00,1, 0,'h00,0);
      tbl[1]  = v(16,     0,1,0,    0,0,   0,  1,'hA5,1, 0,'h00,0);
      tbl[2]  = v(32,     1,0,'h11, 0,0,   0,  0,'hA5,1, 0,'h00,0);
      tbl[3]  = v(32,     1,1,'h22, 0,0,   0,  1,'h11,1, 0,'h00,0);
      tbl[4]  = v(32,     0,1,0,    0,0,   0,  1,'h22,1, 0,'h00,0);
      tbl[5]  = v(0,      0,0,0,    1,'h3C,0,  0,'h22,0, 0,'h00,0);
      tbl[6]  = v(A_IN,   0,1,0,    1,'h99,0,  1,'h3C,1, 0,'h00,0);
      tbl[7]  = v(A_IN,   0,1,0,    0,0,   0,  1,'h00,1, 0,'h00,0);
      tbl[8]  = v(A_OUT,  1,0,'h55, 0,0,   0,  0,'h00,1, 1,'h55,0);
      tbl[9]  = v(A_OUT,  1,0,'h66, 0,0,   0,  0,'h00,1, 1,'h55,1);
      tbl[10] = v(A_STAT, 0,1,0,    0,0,   0,  1,'h06,1, 1,'h55,1);
      tbl[11] = v(A_OUT,  1,0,'h77, 0,0,   1,  0,'h06,1, 1,'h77,1);
      tbl[12] = v(0,      0,0,0,    0,0,   1,  0,'h06,1, 0,'h77,1);
      tbl[13] = v(A_STAT, 1,0,'h01, 0,0,   0,  0,'h06,1, 0,'h77,0);
      tbl[14] = v(A_OUT,  0,1,0,    0,0,   0,  1,'h77,1, 0,'h77,0);
      tbl[15] = v(A_IN,   1,0,'hEE, 0,0,   0,  0,'h77,1, 0,'h77,0);
      tbl[16] = v(A_IN,   0,1,0,    0,0,   0,  1,'h00,1, 0,'h77,0);

      // Asynchronous reset takes effect before any clock edge
      drive('0, 0, 0, '0, 0, '0, 0);
      #3;
      check("reset_state", pack(0, 0, 1, 0, 0, 0));
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].a, tbl[i].we, tbl[i].re, tbl[i].wd, tbl[i].iv, tbl[i].id, tbl[i].ordy);
         tick();
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Build up state: input FULL, output pending, ovf set, rd_data non-zero
      drive('0, 0, 0, '0, 1, 'h5A, 0);            tick();
      drive(AW'(A_OUT), 1, 0, 'h12, 0, '0, 0);    tick();
      drive(AW'(A_OUT), 1, 0, 'h34, 0, '0, 0);    tick();
      drive(AW'(32), 0, 1, '0, 0, '0, 0);         tick();
      check("pre_reset", pack(1, 'h22, 0, 1, 'h12, 1));

      // Reset asserted mid-cycle while a read is being presented
      drive(AW'(16), 0, 1, '0, 0, '0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", pack(0, 0, 1, 0, 0, 0));
      tick();
      rst_n = 1'b1;
      drive('0, 0, 0, '0, 0, '0, 0);
      tick();
      check("after_release", pack(0, 0, 1, 0, 0, 0));
      drive(AW'(16), 0, 1, '0, 0, '0, 0);
      tick();
      check("ram_kept", pack(1, 'hA5, 1, 0, 0, 0));

      // Randomized phase against the model
      m_inq.delete();
      m_out_data = '0; m_out_valid = 1'b0; m_ovf = 1'b0;
      m_rd_data = 'hA5; m_rd_valid = 1'b1;
      for (int i = 0; i < 16; i++)
         rand_cycle(i, 1, 0, DW'($urandom), 0, '0, 0, "prefill");
      for (int i = A_STAT - 5; i < A_STAT; i++)
         rand_cycle(i, 1, 0, DW'($urandom), 0, '0, 0, "prefill");
      for (int n = 0; n < 2000; n++) begin
         int sel, a;
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       a = int'($urandom_range(0, 15));
         else if (sel == 6) a = int'($urandom_range(A_STAT - 5, A_STAT - 1));
         else if (sel == 7) a = A_IN;
         else if (sel == 8) a = A_OUT;
         else               a = A_STAT;
         rand_cycle(a, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, DW'($urandom),
                    $urandom_range(0, 1) == 0, DW'($urandom), $urandom_range(0, 2) == 0,
                    $sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (≥3).
REQ-002 Parameter ADDR_W, default 10, address width; depth = 2^ADDR_W words.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port addr  in  ADDR_W  CPU word address.
REQ-006 Port wr_en  in  1  CPU write strobe, sampled at clk rise.
REQ-007 Port rd_en  in  1  CPU read strobe, sampled at clk rise.
REQ-008 Port wr_data  in  DATA_W  CPU write data.
REQ-009 Port rd_data  out  DATA_W  registered CPU read data.
REQ-010 Port rd_valid  out  1  rd_data valid, one cycle after an accepted read.
REQ-011 Port in_port_data  in  DATA_W  external input-port data.
REQ-012 Port in_port_valid  in  1  external input data offered.
REQ-013 Port in_port_ready  out  1  input holding register empty.
REQ-014 Port out_port_data  out  DATA_W  output-port data register.
REQ-015 Port out_port_valid  out  1  output register holds undelivered data.
REQ-016 Port out_port_ready  in  1  external consumer accepts output data.
REQ-017 Port ovf  out  1  sticky output-port overflow flag.

Function
REQ-018 Address map SHALL be: IN_ADDR = all-ones, OUT_ADDR = all-ones−1, STAT_ADDR = all-ones−2; all other addresses map to RAM.
REQ-019 RAM write: wr_en at RAM address SHALL store wr_data at that address on the clock edge.
REQ-020 RAM read: rd_en at RAM address SHALL load rd_data with the pre-edge contents (read-before-write when wr_en same address), rd_valid=1 next cycle.
REQ-021 rd_valid SHALL be 1 exactly in the cycle after each cycle with rd_en=1, for any address; otherwise 0.
REQ-022 When rd_valid=0, rd_data SHALL hold its last value (no tristate).
REQ-023 Input holding register states: EMPTY (in_port_ready=1), FULL (in_port_ready=0).
REQ-024 EMPTY→FULL when in_port_valid=1 at clock edge; in_port_data captured.
REQ-025 rd_en at IN_ADDR in FULL SHALL return held data and go FULL→EMPTY; in EMPTY SHALL return 0 and stay EMPTY.
REQ-026 Input read and new in_port_valid in the same cycle SHALL not capture (ready was 0); capture occurs the cycle after EMPTY is reached.
REQ-027 wr_en at IN_ADDR SHALL be ignored.
REQ-028 Output register: wr_en at OUT_ADDR when out_port_valid=0, or when out_port_valid=1 and out_port_ready=1 same cycle, SHALL load wr_data and set out_port_valid=1.
REQ-029 wr_en at OUT_ADDR when out_port_valid=1 and out_port_ready=0 SHALL drop the data, leave out_port_data unchanged, and set ovf=1.
REQ-030 out_port_valid=1 and out_port_ready=1 with no OUT_ADDR write SHALL clear out_port_valid; out_port_data held.
REQ-031 rd_en at OUT_ADDR SHALL return out_port_data with no side effects.
REQ-032 rd_en at STAT_ADDR SHALL return {zeros, ovf, out_port_valid, ~in_port_ready} (bit2..bit0).
REQ-033 wr_en at STAT_ADDR with wr_data[0]=1 SHALL clear ovf; an overflow event in the same cycle wins (ovf stays 1).
REQ-034 Port-register addresses SHALL never read or modify RAM contents.

Reset
REQ-035 rst_n=0 SHALL immediately force rd_data=0, rd_valid=0, input register EMPTY (in_port_ready=1), out_port_data=0, out_port_valid=0, ovf=0.
REQ-036 RAM contents SHALL not be reset; reset mid-operation discards any in-flight read (rd_valid=0 after release) and held port data.

Verification
REQ-037 Write 0xA5 to addr 0x010, then rd_en addr 0x010 -> rd_data=0xA5, rd_valid=1 one cycle later.
REQ-038 Same-cycle wr_en+rd_en addr 0x020 (old 0x11, new 0x22) -> rd_data=0x11; next read -> 0x22.
REQ-039 in_port_valid=1 data 0x3C -> in_port_ready=0; rd_en IN_ADDR -> rd_data=0x3C, in_port_ready=1; second read -> 0x00.
REQ-040 Write 0x55 to OUT_ADDR with out_port_ready=0, then write 0x66 -> out_port_data=0x55, ovf=1; STAT read -> 0x06 (input empty).
REQ-041 out_port_valid=1, out_port_ready=1 and OUT_ADDR write 0x77 same cycle -> out_port_data=0x77, out_port_valid=1, ovf unchanged.
REQ-042 Assert rst_n=0 asynchronously mid-read with ovf=1 and input FULL -> all outputs per REQ-035 before next edge; RAM word 0x010 still 0xA5.
